// File: rtl/instr_buffer_if.sv
// Load/fetch bundle for the program buffer; master is the loader/fetch side, slave is the buffer.
interface instr_buffer_if #(
  parameter int INSTR_W = 32
);
  typedef logic [INSTR_W-1:0] instruction_t;
  typedef struct packed {
    logic         v;
    instruction_t instr;
  } instr_t;

  logic         I_Clr;
  logic         I_We;
  instruction_t I_Instr_W;
  logic         I_Seal;
  logic         I_Re;
  logic         I_Rewind;
  instr_t       O_Instr;
  logic         O_Empty;
  logic         O_Full;
  logic         O_Term;
  logic         O_Err;

  modport master (
    output I_Clr, I_We, I_Instr_W, I_Seal, I_Re, I_Rewind,
    input  O_Instr, O_Empty, O_Full, O_Term, O_Err
  );

  modport slave (
    input  I_Clr, I_We, I_Instr_W, I_Seal, I_Re, I_Rewind,
    output O_Instr, O_Empty, O_Full, O_Term, O_Err
  );
endinterface

// File: rtl/instr_buffer.sv
// Replayable program buffer: load once, stream out on I_Re with 1-cycle latency, rewind to replay.
// No backpressure: illegal writes are dropped and flagged, reads on empty are ignored.
module instr_buffer #(
  parameter int DEPTH     = 64,
  parameter int INSTR_W   = 32,
  parameter int WIDTH_CNT = $clog2(DEPTH) + 1
) (
  input logic           clock,
  input logic           reset,
  instr_buffer_if.slave bus
);
  localparam logic [WIDTH_CNT-1:0] FULL_CNT = WIDTH_CNT'(DEPTH);
  localparam logic [WIDTH_CNT-1:0] ONE      = WIDTH_CNT'(1);

  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [WIDTH_CNT-1:0] w_cnt;
  logic [WIDTH_CNT-1:0] r_cnt;
  logic                 sealed;
  logic                 err;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_v;
  logic                 r_term;
  logic                 rst_meta;
  logic                 rst_sync;
  logic                 empty;
  logic                 full;
  logic                 wr_ok;
  logic                 wr_bad;
  logic                 rd_ok;

  // Assertion is immediate; release is retimed to the clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign empty  = (r_cnt == w_cnt);
  assign full   = (w_cnt == FULL_CNT);
  assign wr_ok  = bus.I_We & ~full & ~sealed & ~bus.I_Clr;
  assign wr_bad = bus.I_We & (full | sealed);
  // Emptiness is judged on the pre-edge counters, so a same-cycle write cannot feed a read.
  assign rd_ok  = bus.I_Re & ~empty & ~bus.I_Rewind & ~bus.I_Clr;

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[w_cnt[WIDTH_CNT-2:0]] <= bus.I_Instr_W;
    end
  end

  always_ff @(posedge clock or negedge rst_sync) begin
    if (!rst_sync) begin
      w_cnt   <= '0;
      r_cnt   <= '0;
      sealed  <= 1'b0;
      err     <= 1'b0;
      r_instr <= '0;
      r_v     <= 1'b0;
      r_term  <= 1'b0;
    end else if (bus.I_Clr) begin
      w_cnt  <= '0;
      r_cnt  <= '0;
      sealed <= 1'b0;
      err    <= 1'b0;
      r_v    <= 1'b0;
      r_term <= 1'b0;
    end else begin
      if (wr_ok) begin
        w_cnt <= w_cnt + ONE;
      end
      if (wr_bad) begin
        err <= 1'b1;
      end
      if (bus.I_Seal) begin
        sealed <= 1'b1;
      end
      if (bus.I_Rewind) begin
        r_cnt <= '0;
      end else if (rd_ok) begin
        r_cnt <= r_cnt + ONE;
      end
      if (rd_ok) begin
        r_instr <= mem[r_cnt[WIDTH_CNT-2:0]];
      end
      r_v    <= rd_ok;
      r_term <= rd_ok & sealed & (r_cnt == w_cnt - ONE);
    end
  end

  assign bus.O_Instr.v     = r_v;
  assign bus.O_Instr.instr = r_instr;
  assign bus.O_Empty       = empty;
  assign bus.O_Full        = full;
  assign bus.O_Term        = r_term;
  assign bus.O_Err         = err;
endmodule
